// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: buffers a host coefficient set, then bursts it into the FIR FSM coefficient RAM (FIR_COEFF_SYM_EN: symmetric half-set upload)
module fir_coeff_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iCoeffStart,
  input  logic [ADDR_W-1:0] iNumOfCoeff,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  input  logic              iFirIdle,
  output logic              oCoeffUpdateFlag,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic [ADDR_W-1:0] oNumOfCoeff,
  output logic              oBusy,
  output logic              oUpdateDone,
  output logic              oErr
);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, BURST, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wc_q, wc_d, tc_q, tc_d, num_q, num_d, addr_q, addr_d;
  logic [ADDR_W-1:0] last_w, tc_nx, rd_idx;
  logic [DATA_W-1:0] wrdt_q, wrdt_d;
  logic flag_q, flag_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] buf_q [2**ADDR_W];
  assign tc_nx = (state_q == BURST) ? tc_q + 1'b1 : '0;
`ifdef FIR_COEFF_SYM_EN
  logic [ADDR_W-1:0] mir;
  assign last_w = (num_q >> 1) + {{(ADDR_W-1){1'b0}}, num_q[0]} - 1'b1;
  assign mir    = num_q - 1'b1 - tc_nx;
  assign rd_idx = (tc_nx <= mir) ? tc_nx : mir;
`else
  assign last_w = num_q - 1'b1;
  assign rd_idx = tc_nx;
`endif
  assign oCoeffReady      = (state_q == LOAD);
  assign oBusy            = (state_q != IDLE);
  assign oCoeffUpdateFlag = flag_q;
  assign oAddrRam         = addr_q;
  assign oWrDtRam         = wrdt_q;
  assign oNumOfCoeff      = num_q;
  assign oUpdateDone      = done_q;
  assign oErr             = err_q;
  // shadow buffer fills in tap order while loading; contents survive reset
  always_ff @(posedge iClk12M) begin
    if (state_q == LOAD && iCoeffValid) buf_q[wc_q] <= iCoeffData;
  end
  // state, counters and registered FSM-facing outputs
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= IDLE;
      wc_q    <= '0;
      tc_q    <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      wrdt_q  <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      tc_q    <= tc_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      wrdt_q  <= wrdt_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // next state: collect words, wait for the FSM to go idle, then write one tap per cycle
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    tc_d    = tc_q;
    num_d   = num_q;
    addr_d  = addr_q;
    wrdt_d  = wrdt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (iCoeffStart) begin
        err_d = (iNumOfCoeff == '0);
        if (iNumOfCoeff != '0) begin
          num_d   = iNumOfCoeff;
          wc_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: if (iCoeffValid) begin
        wc_d = wc_q + 1'b1;
        if (wc_q == last_w) begin
          state_d = REQ;
          flag_d  = 1'b1;
          addr_d  = '0;
          wrdt_d  = '0;
        end
      end
      REQ: if (iFirIdle) begin
        state_d = BURST;
        tc_d    = '0;
        addr_d  = tc_nx;
        wrdt_d  = buf_q[rd_idx];
      end
      BURST: begin
        tc_d    = (tc_q == num_q - 1'b1) ? tc_q : tc_nx;
        addr_d  = (tc_q == num_q - 1'b1) ? '0 : tc_nx;
        wrdt_d  = (tc_q == num_q - 1'b1) ? '0 : buf_q[rd_idx];
        flag_d  = (tc_q != num_q - 1'b1);
        done_d  = (tc_q == num_q - 1'b1);
        state_d = (tc_q == num_q - 1'b1) ? DONE : BURST;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed stimulus, cycle model of the loader, per-cycle compare plus literal burst checks
module tb_fir_coeff_loader;
`ifdef FIR_COEFF_SYM_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, fir_idle = 1'b0;
  logic [5:0] n_in = '0;
  logic [15:0] data = '0;
  logic ready, flag, busy, updone, err;
  logic [5:0] addr, num;
  logic [15:0] wrdt;
  fir_coeff_loader dut (
    .iClk12M(clk), .iRst(rst), .iCoeffStart(start), .iNumOfCoeff(n_in),
    .iCoeffValid(valid), .iCoeffData(data), .oCoeffReady(ready), .iFirIdle(fir_idle),
    .oCoeffUpdateFlag(flag), .oAddrRam(addr), .oWrDtRam(wrdt), .oNumOfCoeff(num),
    .oBusy(busy), .oUpdateDone(updone), .oErr(err)
  );
  always #5 clk = ~clk;
  int vc = 0, ec = 0;
  bit cmp_en = 1'b0;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    vc++;
    if (a !== e) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      ec++;
    end
  endtask
  function automatic int need(int n);
    return SYM ? (n + 1) / 2 : n;
  endfunction
  int m_mode = 0, m_tap = 0;
  bit m_flag = 0, m_done = 0, m_err = 0;
  logic [5:0] m_addr = '0, m_num = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_words[$];
  function automatic logic [15:0] tapval(int t);
    int n = int'(m_num);
    int mirror = n - 1 - t;
    return m_words[(SYM && mirror < t) ? mirror : t];
  endfunction
  always @(posedge clk) begin
    m_done = 0;
    m_err = 0;
    if (rst) begin
      m_mode = 0; m_flag = 0; m_addr = '0; m_data = '0; m_num = '0;
      m_words.delete();
    end else case (m_mode)
      0: if (start) begin
        if (n_in == 0) m_err = 1;
        else begin m_num = n_in; m_words.delete(); m_mode = 1; end
      end
      1: if (valid) begin
        m_words.push_back(data);
        if (m_words.size() == need(int'(m_num))) begin
          m_mode = 2; m_flag = 1; m_addr = '0; m_data = '0;
        end
      end
      2: if (fir_idle) begin
        m_mode = 3; m_tap = 0; m_addr = '0; m_data = tapval(0);
      end
      3: if (m_tap == int'(m_num) - 1) begin
        m_mode = 4; m_flag = 0; m_addr = '0; m_data = '0; m_done = 1;
      end else begin
        m_tap++; m_addr = 6'(m_tap); m_data = tapval(m_tap);
      end
      default: m_mode = 0;
    endcase
  end
  int flag_cnt = 0, done_cnt = 0, wr_cnt = 0;
  logic [15:0] seq [256];
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", ready, m_mode == 1);
      chk("busy", busy, m_mode != 0);
      chk("flag", flag, m_flag);
      chk("addr", addr, m_addr);
      chk("wrdt", wrdt, m_data);
      chk("num", num, m_num);
      chk("done", updone, m_done);
      chk("err", err, m_err);
      chk("words_pending", m_words.size() <= 64, 1);
      if (flag) flag_cnt++;
      if (updone) done_cnt++;
      if (m_mode == 3 && wr_cnt < 256) begin seq[wr_cnt] = wrdt; wr_cnt++; end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic go(input logic [5:0] n);
    start = 1; n_in = n; tick(); start = 0;
  endtask
  task automatic send(input int cnt, input logic [15:0] base, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      valid = 1; data = base + 16'(i); tick();
      if (gap) begin valid = 0; tick(); end
    end
    valid = 0; data = '0;
  endtask
  task automatic wait_done();
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < 300) begin tick(); c++; end
    chk("done_timeout", done_cnt != d0, 1);
    tick();
  endtask
  logic [15:0] e1 [8];
  logic [15:0] e2 [5];
  logic [15:0] e3 [3];
  int w0, f0, d0;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    if (SYM) begin
      e1 = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0104, 16'h0103, 16'h0102, 16'h0101};
      e2 = '{16'h0201, 16'h0202, 16'h0203, 16'h0202, 16'h0201};
      e3 = '{16'h0301, 16'h0302, 16'h0301};
    end else begin
      e1 = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0108};
      e2 = '{16'h0201, 16'h0202, 16'h0203, 16'h0204, 16'h0205};
      e3 = '{16'h0301, 16'h0302, 16'h0303};
    end
    tick(); cmp_en = 1; tick(); tick();
    rst = 0;
    repeat (10) tick();
    chk("idle_busy", busy, 0);
    chk("idle_flag", flag, 0);
    chk("idle_num", num, 0);
    fir_idle = 1; w0 = wr_cnt; f0 = flag_cnt; d0 = done_cnt;
    go(8);
    send(need(8), 16'h0101, 0);
    wait_done();
    for (int i = 0; i < 8; i++) chk($sformatf("n8_tap%0d", i), seq[w0 + i], e1[i]);
    chk("n8_writes", wr_cnt - w0, 8);
    chk("n8_flag_cycles", flag_cnt - f0, 9);
    chk("n8_done_pulses", done_cnt - d0, 1);
    chk("n8_num", num, 8);
    fir_idle = 0; w0 = wr_cnt;
    go(5);
    send(need(5), 16'h0201, 0);
    repeat (20) tick();
    chk("req_flag_held", flag, 1);
    chk("req_addr", addr, 0);
    chk("req_no_writes", wr_cnt - w0, 0);
    fir_idle = 1;
    wait_done();
    for (int i = 0; i < 5; i++) chk($sformatf("n5_tap%0d", i), seq[w0 + i], e2[i]);
    chk("n5_writes", wr_cnt - w0, 5);
    w0 = wr_cnt;
    go(3);
    send(need(3), 16'h0301, 1);
    valid = 1; data = 16'hdead;
    chk("extra_not_ready", ready, 0);
    tick(); valid = 0; data = '0;
    wait_done();
    for (int i = 0; i < 3; i++) chk($sformatf("n3_tap%0d", i), seq[w0 + i], e3[i]);
    chk("n3_writes", wr_cnt - w0, 3);
    go(0);
    chk("err_pulse", err, 1);
    chk("err_idle", busy, 0);
    tick();
    chk("err_one_cycle", err, 0);
    go(7);
    go(9);
    chk("restart_ignored_num", num, 7);
    send(need(7), 16'h0701, 0);
    wait_done();
    go(16);
    send(need(16), 16'h1001, 0);
    tick(); tick(); tick();
    chk("burst_flag_before_rst", flag, 1);
    rst = 1; tick();
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_num", num, 0);
    rst = 0; tick();
`ifdef FIR_COEFF_SYM_EN
    w0 = wr_cnt;
    go(5);
    send(3, 16'hA001, 0);
    wait_done();
    chk("sym_t0", seq[w0], 16'hA001);
    chk("sym_t1", seq[w0 + 1], 16'hA002);
    chk("sym_t2", seq[w0 + 2], 16'hA003);
    chk("sym_t3", seq[w0 + 3], 16'hA002);
    chk("sym_t4", seq[w0 + 4], 16'hA001);
`endif
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vc, ec);
    $finish;
  end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Upstream neighbour of the FIR control FSM.
- Collects a coefficient set from the host over a valid/ready stream into a shadow buffer.
- Once the set is complete, burst-writes it into the FSM's coefficient RAM write port.
- Drives the FSM's coefficient-update inputs, i.e. the update flag, address, data and tap count. It raises the flag only so that the FSM captures the burst from its idle state.

Parameters:
- DATA_W, 16, coefficient width.
- ADDR_W, 6, coefficient address width. Maximum tap count is 2^ADDR_W - 1 = 63.

Ports:
- iClk12M  in  1  system clock. All logic is on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iCoeffStart  in  1  one-cycle pulse that opens a new coefficient set. Honoured only in IDLE.
- iNumOfCoeff  in  ADDR_W  tap count N, sampled on iCoeffStart.
- iCoeffValid  in  1  host coefficient word valid.
- iCoeffData  in  DATA_W  host coefficient word, sent in tap order 0..N-1.
- oCoeffReady  out  1  block can accept a word.
- iFirIdle  in  1  high while the downstream FSM is in its idle or write-end state.
- oCoeffUpdateFlag  out  1  update request / write window to the FSM.
- oAddrRam  out  ADDR_W  tap address. Bits [1:0] select the bank, bits [5:2] the word.
- oWrDtRam  out  DATA_W  coefficient written at oAddrRam.
- oNumOfCoeff  out  ADDR_W  latched N, held stable from LOAD until the next iCoeffStart.
- oBusy  out  1  high in any state other than IDLE.
- oUpdateDone  out  1  one-cycle pulse when the burst completes.
- oErr  out  1  one-cycle pulse when iCoeffStart is rejected.

Behaviour:
- Reset (iRst=1 at an edge):
  - State goes to IDLE.
  - All outputs are 0, including oNumOfCoeff, oAddrRam and oWrDtRam.
  - Counters clear. Buffer contents are don't-care.
- States: IDLE, LOAD, REQ, BURST, DONE.
- IDLE:
  - oCoeffReady=0.
  - iCoeffStart with N=0: stay in IDLE and pulse oErr the next cycle.
  - iCoeffStart with N>0: latch N into oNumOfCoeff, clear the word counter wc, go to LOAD.
- LOAD:
  - oCoeffReady=1.
  - Each cycle with iCoeffValid && oCoeffReady: buf[wc] <= iCoeffData, wc <= wc+1.
  - On the accept where wc == W-1, go to REQ, with W the word count (N, or (N+1)/2 with the optional feature). oCoeffReady drops in the next cycle.
  - iCoeffStart in LOAD is ignored.
- REQ:
  - oCoeffUpdateFlag=1, oAddrRam=0, oWrDtRam=0.
  - Stay in REQ while iFirIdle=0; the flag is held high throughout.
  - At the first edge with iFirIdle=1, the FSM takes the flag. The loader clears the tap counter tc and goes to BURST.
- BURST:
  - oCoeffUpdateFlag=1, oAddrRam=tc, oWrDtRam=buf[tc]. One tap is written per cycle, all outputs registered.
  - When tc == N-1, go to DONE. The burst lasts exactly N cycles.
  - iFirIdle is not examined; the FSM is held in its write state by the flag.
- DONE:
  - oCoeffUpdateFlag=0 and oUpdateDone=1 for one cycle, then IDLE. The FSM moves to write-end.
- Cycle timing: the flag rises on the edge entering REQ. First data appears in cycle 1 of BURST. The flag falls on the edge entering DONE.
- iCoeffStart arriving in the same cycle as DONE is ignored.
- Reset mid-operation (LOAD/REQ/BURST): flag drops the next cycle. A partially written RAM is acceptable; the host must reload.
- Arithmetic:
  - Counters are ADDR_W bits and never wrap, since the maximum N is 63.
  - The buffer is 2^ADDR_W × DATA_W and is not reset.

Optional Feature:
- Macro: FIR_COEFF_SYM_EN.
- Defined (symmetric-filter mode):
  - In LOAD the host sends only W=(N+1)/2 words, for taps 0..W-1.
  - BURST still writes all N taps, with oWrDtRam = buf[min(tc, N-1-tc)].
  - For odd N the centre tap is sent once.
- Undefined: W=N and oWrDtRam=buf[tc].

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, oCoeffReady=0, oBusy=0.
- Start with N=8, send words 0x0101..0x0108 with iFirIdle=1 -> flag high for 1+8 cycles; oAddrRam 0..7 carries 0x0101..0x0108; oUpdateDone pulses once; oNumOfCoeff=8.
- N=5 with iFirIdle held 0 for 20 cycles in REQ -> flag held high, no address change; burst of 5 starts one cycle after iFirIdle rises.
- N=3 with iCoeffValid toggling every other cycle -> exactly 3 words accepted; a fourth valid word after the last accept is not accepted (oCoeffReady=0).
- iCoeffStart with N=0 -> oErr pulses, state stays IDLE. A second iCoeffStart during LOAD is ignored and the latched N is unchanged.
- Reset asserted in cycle 3 of a BURST with N=16 -> flag 0 on the next cycle. With FIR_COEFF_SYM_EN, N=5 and words A,B,C -> written sequence is A,B,C,B,A.
